apb_master: RTL and testbench

- APB requester that sits directly upstream of the team's APB slave memory blocks in the apb2apb bridge.
- Converts a simple valid/ready command interface into legal APB SETUP/ACCESS transfers.
- Waits on pready, captures prdata/pslverr, and returns one response per command through a single-entry response register.
- Adds a programmable wait-state timeout so a hung slave cannot stall the bridge.

---
 rtl/apb_master.sv | 164 ++++++++++++++++
 tb/tb_apb_master.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
`default_nettype none
// ============================================================================
// Module   : apb_master
// Brief    : valid/ready command to APB requester with wait-state timeout
// Revision : 1.0
// ============================================================================
module apb_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic                  pready,
    input  logic                  pslverr,
    input  logic [DATA_WIDTH-1:0] prdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // Counter value seen on the last permitted ACCESS cycle without pready.
    localparam logic [15:0] C_TO_LAST = 16'(TIMEOUT - 1);
    localparam logic        C_TO_EN   = (TIMEOUT != 0);

    state_t                  state_q, state_d;
    logic                    psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic                    pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_err_q, rsp_err_d;
    logic                    rsp_timeout_q, rsp_timeout_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [15:0]             cnt_q, cnt_d;
    logic                    cmd_hs;

    assign cmd_ready = (state_q == IDLE) & ~rsp_valid_q;
    assign cmd_hs    = cmd_valid & cmd_ready;

    always_comb begin
        state_d       = state_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        rsp_rdata_d   = rsp_rdata_q;
        cnt_d         = cnt_q;

        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (cmd_hs) begin
                    pwrite_d = cmd_write;
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                    psel_d   = 1'b1;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                cnt_d     = 16'd0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // pready is checked first so it wins over a same-cycle timeout.
                if (pready) begin
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = pslverr;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = (~pwrite_q & ~pslverr) ? prdata : '0;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    cnt_d         = 16'd0;
                    state_d       = IDLE;
                end else if (C_TO_EN && (cnt_q == C_TO_LAST)) begin
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    cnt_d         = 16'd0;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                cnt_d     = 16'd0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= '0;
            cnt_q         <= 16'd0;
        end else begin
            state_q       <= state_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_rdata_q   <= rsp_rdata_d;
            cnt_q         <= cnt_d;
        end
    end

    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign rsp_rdata   = rsp_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_master
// Brief    : directed self-checking bench for apb_master with a 256-word slave
// Revision : 1.0
// ============================================================================
module tb_apb_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        psel, penable, pwrite, pready, pslverr;
    logic [31:0] paddr, pwdata, prdata;

    int checks = 0;
    int errors = 0;

    // Slave model: word-indexed memory, error above 255, programmable waits.
    logic [31:0] mem [0:255];
    int          wait_states = 0;
    logic        stuck = 1'b0;
    int          acc_cnt = 0;

    assign pslverr = (paddr >= 32'd256);
    assign prdata  = mem[paddr[7:0]];
    assign pready  = psel & penable & ~stuck & (acc_cnt == wait_states);

    always @(posedge clk) begin
        if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
        else                            acc_cnt <= 0;
        if (psel && penable && pready && pwrite && !pslverr) mem[paddr[7:0]] <= pwdata;
    end

    always #5 clk = ~clk;

    apb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .pready(pready), .pslverr(pslverr), .prdata(prdata)
    );

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, output bit ok);
        ok        = 1'b0;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (cmd_ready) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
    endtask

    // Cycles after the accept edge until rsp_valid (0 = never), penable cycles, paddr stability.
    task automatic wait_rsp(input int max, output int lat, output int pen, output bit stable);
        logic [31:0] a0;
        a0     = paddr;
        lat    = 0;
        pen    = 0;
        stable = 1'b1;
        for (int i = 1; i <= max; i++) begin
            @(posedge clk); #1;
            if (penable) begin
                pen++;
                if (paddr !== a0) stable = 1'b0;
            end
            if (rsp_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout} !== 6'b0 ||
            paddr !== 32'd0 || pwdata !== 32'd0 || rsp_rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: psel=%0b pen=%0b pwr=%0b rv=%0b re=%0b rt=%0b paddr=%h pwdata=%h rdata=%h want all 0",
                     psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout, paddr, pwdata, rsp_rdata);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_cmd_ready: got %0b want 1", cmd_ready);
        end
    endtask

    task automatic test_write_read();
        bit ok; int lat, pen; bit st;
        issue(1'b1, 32'h10, 32'hDEADBEEF, ok);
        checks++;
        if (!ok || psel !== 1'b1 || penable !== 1'b0 || pwrite !== 1'b1 || paddr !== 32'h10 || pwdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL wr_setup: ok=%0b psel=%0b pen=%0b pwr=%0b paddr=%h pwdata=%h want 1 1 0 1 10 deadbeef",
                     ok, psel, penable, pwrite, paddr, pwdata);
        end
        @(posedge clk); #1;
        checks++;
        if (psel !== 1'b1 || penable !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL wr_access: psel=%0b pen=%0b rv=%0b want 1 1 0", psel, penable, rsp_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'd0 || psel !== 1'b0 || penable !== 1'b0) begin
            errors++;
            $display("FAIL wr_rsp: rv=%0b err=%0b rdata=%h psel=%0b pen=%0b want 1 0 0 0 0",
                     rsp_valid, rsp_err, rsp_rdata, psel, penable);
        end
        consume();
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL wr_consume: rv=%0b cmd_ready=%0b want 0 1", rsp_valid, cmd_ready);
        end
        issue(1'b0, 32'h10, 32'h0, ok);
        wait_rsp(10, lat, pen, st);
        checks++;
        if (!ok || lat !== 2 || rsp_rdata !== 32'hDEADBEEF || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL rd_back: ok=%0b lat=%0d rdata=%h err=%0b want 1 2 deadbeef 0", ok, lat, rsp_rdata, rsp_err);
        end
        consume();
    endtask

    task automatic test_slverr();
        bit ok; int lat, pen; bit st;
        issue(1'b0, 32'h100, 32'h0, ok);
        wait_rsp(10, lat, pen, st);
        checks++;
        if (!ok || lat !== 2 || rsp_err !== 1'b1 || rsp_timeout !== 1'b0 || rsp_rdata !== 32'd0) begin
            errors++;
            $display("FAIL slverr: ok=%0b lat=%0d err=%0b to=%0b rdata=%h want 1 2 1 0 0",
                     ok, lat, rsp_err, rsp_timeout, rsp_rdata);
        end
        consume();
    endtask

    task automatic test_wait_states();
        bit ok; int lat, pen; bit st;
        wait_states = 3;
        issue(1'b0, 32'h04, 32'h0, ok);
        wait_rsp(20, lat, pen, st);
        checks++;
        if (!ok || lat !== 5 || pen !== 4 || !st) begin
            errors++;
            $display("FAIL wait_timing: ok=%0b lat=%0d pen_cycles=%0d stable=%0b want 1 5 4 1", ok, lat, pen, st);
        end
        checks++;
        if (rsp_rdata !== 32'h12345678 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL wait_data: rdata=%h err=%0b want 12345678 0", rsp_rdata, rsp_err);
        end
        consume();
        wait_states = 0;
    endtask

    task automatic test_timeout();
        bit ok; int lat, pen; bit st;
        stuck = 1'b1;
        issue(1'b0, 32'h08, 32'h0, ok);
        wait_rsp(40, lat, pen, st);
        checks++;
        if (!ok || lat !== 17 || pen !== 16) begin
            errors++;
            $display("FAIL timeout_timing: ok=%0b lat=%0d pen_cycles=%0d want 1 17 16", ok, lat, pen);
        end
        checks++;
        if (rsp_err !== 1'b1 || rsp_timeout !== 1'b1 || rsp_rdata !== 32'd0 || psel !== 1'b0 || penable !== 1'b0) begin
            errors++;
            $display("FAIL timeout_rsp: err=%0b to=%0b rdata=%h psel=%0b pen=%0b want 1 1 0 0 0",
                     rsp_err, rsp_timeout, rsp_rdata, psel, penable);
        end
        stuck = 1'b0;
        consume();
        issue(1'b1, 32'h20, 32'hCAFEF00D, ok);
        wait_rsp(10, lat, pen, st);
        checks++;
        if (!ok || lat !== 2 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0 || mem[32] !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL after_timeout: ok=%0b lat=%0d err=%0b to=%0b mem=%h want 1 2 0 0 cafef00d",
                     ok, lat, rsp_err, rsp_timeout, mem[32]);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        bit ok; int lat, pen; bit st; bit held;
        issue(1'b0, 32'h04, 32'h0, ok);
        wait_rsp(10, lat, pen, st);
        cmd_write = 1'b1;
        cmd_addr  = 32'h30;
        cmd_wdata = 32'h0BADCAFE;
        cmd_valid = 1'b1;
        held = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== 32'h12345678 || rsp_err !== 1'b0 || psel !== 1'b0)
                held = 1'b0;
        end
        checks++;
        if (!ok || lat !== 2 || !held) begin
            errors++;
            $display("FAIL backpressure_hold: ok=%0b lat=%0d held=%0b want 1 2 1", ok, lat, held);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || psel !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release: rv=%0b cmd_ready=%0b psel=%0b want 0 1 0", rsp_valid, cmd_ready, psel);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        checks++;
        if (psel !== 1'b1 || penable !== 1'b0 || paddr !== 32'h30 || pwrite !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_accept: psel=%0b pen=%0b paddr=%h pwr=%0b want 1 0 30 1", psel, penable, paddr, pwrite);
        end
        wait_rsp(10, lat, pen, st);
        checks++;
        if (lat !== 2 || mem[48] !== 32'h0BADCAFE) begin
            errors++;
            $display("FAIL backpressure_done: lat=%0d mem=%h want 2 0badcafe", lat, mem[48]);
        end
        consume();
    endtask

    task automatic test_reset_mid();
        bit ok; bit quiet;
        stuck = 1'b1;
        issue(1'b0, 32'h04, 32'h0, ok);
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (!ok || psel !== 1'b0 || penable !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_async: ok=%0b psel=%0b pen=%0b rv=%0b want 1 0 0 0", ok, psel, penable, rsp_valid);
        end
        stuck = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b0 || psel !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_release: quiet=%0b cmd_ready=%0b want 1 1", quiet, cmd_ready);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[4]    = 32'h12345678;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 32'd0;
        cmd_wdata = 32'd0;
        rsp_ready = 1'b0;
        test_reset();
        test_write_read();
        test_slverr();
        test_wait_states();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, want finish before 200000");
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire
